// File: rtl/dmem_bridge_if.sv
// Bus bundle between the core's load/store stage, the bridge and data_mem.
// The bridge takes the slave view; the environment (CPU + data_mem) takes master.
interface dmem_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_fault;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_sign_mask;
  logic        dmem_memwrite;
  logic        dmem_memread;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic [7:0]  led;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, cpu_sign_mask,
    input  dmem_rdata, dmem_stall,
    output cpu_rdata, cpu_stall, cpu_fault,
    output dmem_addr, dmem_wdata, dmem_sign_mask, dmem_memwrite, dmem_memread,
    output led
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, cpu_sign_mask,
    output dmem_rdata, dmem_stall,
    input  cpu_rdata, cpu_stall, cpu_fault,
    input  dmem_addr, dmem_wdata, dmem_sign_mask, dmem_memwrite, dmem_memread,
    input  led
  );
endinterface

// File: rtl/dmem_bridge.sv
// Load/store bridge: latches a CPU data access, routes it to data_mem or to the
// local MMIO block (LED, 64-bit cycle counter, scratch), and faults illegal accesses.
module dmem_bridge #(
  parameter logic [31:0] DMEM_BASE  = 32'h1000,
  parameter int unsigned DMEM_BYTES = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h2000
) (
  input  logic         clk,
  input  logic         reset,
  dmem_bridge_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MMIO, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_wr;
  logic        r_fault;
  logic [31:0] r_rdata;
  logic [31:0] r_led;
  logic [31:0] r_scratch;
  logic [31:0] r_hi_snap;
  logic [63:0] r_cyc;

  logic        w_req;
  logic        w_in_dmem;
  logic        w_mmio_ok;
  logic [31:0] w_dmem_off;
  logic [31:0] w_mmio_off;
  logic [31:0] w_mmio_rd;

  assign w_req      = bus.cpu_memread | bus.cpu_memwrite;
  assign w_dmem_off = bus.cpu_addr - DMEM_BASE;
  assign w_in_dmem  = (w_dmem_off < 32'(DMEM_BYTES));
  assign w_mmio_off = r_addr - MMIO_BASE;

  // Only aligned word accesses inside the 4-register block; stores only to LED and scratch.
  assign w_mmio_ok = r_mask[2] && (w_mmio_off[1:0] == 2'b00) && (w_mmio_off < 32'd16) &&
                     (!r_wr || (w_mmio_off[3:2] == 2'd0) || (w_mmio_off[3:2] == 2'd3));

  always_comb begin
    w_mmio_rd = '0;
    case (w_mmio_off[3:2])
      2'd0:    w_mmio_rd = r_led;
      2'd1:    w_mmio_rd = r_cyc[31:0];
      2'd2:    w_mmio_rd = r_hi_snap;
      default: w_mmio_rd = r_scratch;
    endcase
  end

  assign bus.led = r_led[7:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.cpu_stall      = 1'b0;
    bus.cpu_rdata      = '0;
    bus.cpu_fault      = 1'b0;
    bus.dmem_addr      = '0;
    bus.dmem_wdata     = '0;
    bus.dmem_sign_mask = '0;
    bus.dmem_memwrite  = 1'b0;
    bus.dmem_memread   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cpu_stall = w_req;
        if (w_req) w_next = w_in_dmem ? S_ISSUE : S_MMIO;
      end
      S_ISSUE: begin
        bus.cpu_stall      = 1'b1;
        bus.dmem_addr      = r_addr;
        bus.dmem_wdata     = r_wdata;
        bus.dmem_sign_mask = r_mask;
        if (!bus.dmem_stall) begin
          bus.dmem_memwrite = r_wr;
          bus.dmem_memread  = !r_wr;
          w_next            = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.cpu_stall = 1'b1;
        if (!bus.dmem_stall) w_next = S_DONE;
      end
      S_MMIO: begin
        bus.cpu_stall = 1'b1;
        w_next        = S_DONE;
      end
      S_DONE: begin
        bus.cpu_rdata = r_rdata;
        bus.cpu_fault = r_fault;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Nothing leaves the bridge while reset is held, whatever state it is in.
    if (reset) begin
      bus.cpu_stall     = 1'b0;
      bus.cpu_rdata     = '0;
      bus.cpu_fault     = 1'b0;
      bus.dmem_memwrite = 1'b0;
      bus.dmem_memread  = 1'b0;
    end
  end

  // Request capture, DMEM read-data capture and MMIO register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr      <= 1'b0;
      r_fault   <= 1'b0;
      r_rdata   <= '0;
      r_led     <= '0;
      r_scratch <= '0;
      r_hi_snap <= '0;
      r_cyc     <= '0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_mask  <= bus.cpu_sign_mask;
            r_wr    <= bus.cpu_memwrite;
            r_fault <= 1'b0;
            r_rdata <= '0;
          end
        end
        S_WAIT: begin
          if (!bus.dmem_stall) r_rdata <= r_wr ? 32'd0 : bus.dmem_rdata;
        end
        S_MMIO: begin
          r_fault <= !w_mmio_ok;
          r_rdata <= '0;
          if (w_mmio_ok && r_wr) begin
            if (w_mmio_off[3:2] == 2'd0) r_led     <= r_wdata;
            else                         r_scratch <= r_wdata;
          end else if (w_mmio_ok) begin
            r_rdata <= w_mmio_rd;
            if (w_mmio_off[3:2] == 2'd1) r_hi_snap <= r_cyc[63:32];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a small behavioural data_mem
// (one stall cycle after a read strobe, two after a write, three after reset).
module tb_dmem_bridge;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  dmem_bridge_if bus ();

  dmem_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem model; DMEM window base has zero low bits, so addr[11:0] is the offset
  logic [7:0]  mem [0:4095];
  logic [1:0]  mbusy;
  logic [31:0] mrdata;
  logic [11:0] moff;

  assign moff           = bus.dmem_addr[11:0];
  assign bus.dmem_stall = (mbusy != 2'd0);
  assign bus.dmem_rdata = mrdata;

  function automatic logic [31:0] mload(input logic [11:0] o, input logic [3:0] m);
    logic [31:0] v;
    if (m[2])      v = {mem[o + 12'd3], mem[o + 12'd2], mem[o + 12'd1], mem[o]};
    else if (m[1]) v = {{16{m[3] & mem[o + 12'd1][7]}}, mem[o + 12'd1], mem[o]};
    else           v = {{24{m[3] & mem[o][7]}}, mem[o]};
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mbusy <= 2'd3;
    end else if (mbusy != 2'd0) begin
      mbusy <= mbusy - 2'd1;
    end else if (bus.dmem_memwrite) begin
      mbusy     <= 2'd2;
      mem[moff] <= bus.dmem_wdata[7:0];
      if (bus.dmem_sign_mask[2] | bus.dmem_sign_mask[1]) mem[moff + 12'd1] <= bus.dmem_wdata[15:8];
      if (bus.dmem_sign_mask[2]) begin
        mem[moff + 12'd2] <= bus.dmem_wdata[23:16];
        mem[moff + 12'd3] <= bus.dmem_wdata[31:24];
      end
    end else if (bus.dmem_memread) begin
      mbusy  <= 2'd1;
      mrdata <= mload(moff, bus.dmem_sign_mask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // One CPU access: present in cycle 0, count stall cycles, sample the DONE cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output logic fault,
                        output int stalls, output logic [7:0] led_done);
    logic done;
    @(posedge clk); #1;
    bus.cpu_memwrite  = wr;
    bus.cpu_memread   = rd;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    bus.cpu_sign_mask = mask;
    stalls = 0; done = 1'b0; rdata = '0; fault = 1'b0; led_done = '0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      else begin
        done     = 1'b1;
        rdata    = bus.cpu_rdata;
        fault    = bus.cpu_fault;
        led_done = bus.led;
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cpu_memwrite = 1'b0;
    bus.cpu_memread  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          st;
    logic [7:0]  ld;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.cpu_memwrite = 1'b0; bus.cpu_memread = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_sign_mask = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_fault", 32'(bus.cpu_fault), 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_strobes", {30'd0, bus.dmem_memwrite, bus.dmem_memread}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    access(1'b1, 1'b0, 32'h1010, 32'hDEADBEEF, 4'b0100, rd, flt, st, ld);
    chk("sw_stall", 32'(st), 32'd5);
    chk("sw_fault", 32'(flt), 32'd0);
    access(1'b0, 1'b1, 32'h1010, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_stall", 32'(st), 32'd4);
    chk("lw_fault", 32'(flt), 32'd0);

    access(1'b1, 1'b0, 32'h1013, 32'h00000080, 4'b0000, rd, flt, st, ld);
    access(1'b0, 1'b1, 32'h1013, 32'h0, 4'b1000, rd, flt, st, ld);
    chk("lb_signed", rd, 32'hFFFFFF80);
    access(1'b0, 1'b1, 32'h1013, 32'h0, 4'b0000, rd, flt, st, ld);
    chk("lbu", rd, 32'h00000080);

    access(1'b1, 1'b0, 32'h2000, 32'h000000A5, 4'b0100, rd, flt, st, ld);
    chk("led_sw_stall", 32'(st), 32'd2);
    chk("led_sw_fault", 32'(flt), 32'd0);
    chk("led_in_done", 32'(ld), 32'hA5);
    access(1'b0, 1'b1, 32'h2000, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("led_lw", rd, 32'h000000A5);

    access(1'b1, 1'b1, 32'h200C, 32'hCAFEF00D, 4'b0100, rd, flt, st, ld);
    chk("both_strobes_rdata", rd, 32'h0);
    access(1'b0, 1'b1, 32'h200C, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("scratch_lw", rd, 32'hCAFEF00D);

    // Counter is forced to FFFFFFFF for one cycle, so cyc = 1_00000001 in the MMIO cycle.
    @(negedge clk);
    force dut.r_cyc = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    release dut.r_cyc;
    access(1'b0, 1'b1, 32'h2004, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("cyc_lo", rd, 32'h00000001);
    access(1'b0, 1'b1, 32'h2008, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("cyc_hi_snap", rd, 32'h00000001);

    access(1'b0, 1'b1, 32'h3000, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("unmapped_fault", 32'(flt), 32'd1);
    chk("unmapped_rdata", rd, 32'h0);
    access(1'b0, 1'b1, 32'h0FFC, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("below_dmem_fault", 32'(flt), 32'd1);
    access(1'b1, 1'b0, 32'h2004, 32'h00000055, 4'b0100, rd, flt, st, ld);
    chk("ro_write_fault", 32'(flt), 32'd1);
    access(1'b1, 1'b0, 32'h2000, 32'h000000FF, 4'b0010, rd, flt, st, ld);
    chk("sh_mmio_fault", 32'(flt), 32'd1);
    chk("sh_mmio_led", 32'(ld), 32'hA5);
    access(1'b0, 1'b1, 32'h2002, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("misaligned_fault", 32'(flt), 32'd1);
    chk("misaligned_rdata", rd, 32'h0);
    access(1'b0, 1'b1, 32'h2000, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("led_kept", rd, 32'h000000A5);
    chk("led_ok_nofault", 32'(flt), 32'd0);

    // Reset lands in WAIT of a load while data_mem is still stalling.
    @(posedge clk); #1;
    bus.cpu_addr = 32'h1010; bus.cpu_sign_mask = 4'b0100; bus.cpu_memread = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_wait_stall", 32'(bus.cpu_stall), 32'd1);
    chk("mid_wait_dstall", 32'(bus.dmem_stall), 32'd1);
    reset = 1'b1;
    bus.cpu_memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("post_rst_fault", 32'(bus.cpu_fault), 32'd0);
    chk("post_rst_led", 32'(bus.led), 32'd0);
    access(1'b0, 1'b1, 32'h1010, 32'h0, 4'b0100, rd, flt, st, ld);
    chk("post_rst_lw", rd, 32'h80ADBEEF);
    chk("post_rst_lw_stall", 32'(st), 32'd5);
    chk("post_rst_lw_fault", 32'(flt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
